// File: rtl/pheap_level_ctrl.sv
// One level of a pipelined min-heap: read-compare-write sequencing of the level RAM,
// token forwarding downward and min-child return upward. Optional counters: PHEAP_LEVEL_STATS_EN.
module pheap_level_ctrl #(
  parameter int RAMLEVEL   = 2,
  parameter int ENTRY_W    = 16,
  parameter int KEY_W      = 8,
  parameter int LAST_LEVEL = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic                op_del,
  input  logic [RAMLEVEL-2:0] op_idx,
  input  logic                op_dir,
  input  logic [ENTRY_W-1:0]  op_data,
  output logic                up_valid,
  output logic [ENTRY_W-1:0]  up_data,
  output logic                dn_valid,
  input  logic                dn_ready,
  output logic                dn_del,
  output logic [RAMLEVEL-1:0] dn_idx,
  output logic [ENTRY_W-1:0]  dn_data,
  input  logic                fill_valid,
  input  logic [ENTRY_W-1:0]  fill_data,
  output logic                ram_we_a,
  output logic                ram_we_b,
  output logic [RAMLEVEL-2:0] ram_addr_a,
  output logic [RAMLEVEL-2:0] ram_addr_b,
  output logic [ENTRY_W-1:0]  ram_wd_a,
  output logic [ENTRY_W-1:0]  ram_wd_b,
  input  logic [ENTRY_W-1:0]  ram_q_a,
  input  logic [ENTRY_W-1:0]  ram_q_b,
  output logic                overflow
`ifdef PHEAP_LEVEL_STATS_EN
  ,
  output logic [15:0]         ins_cnt,
  output logic [15:0]         del_cnt
`endif
);
  localparam int AW = RAMLEVEL - 1;

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_FWD, S_WAIT_FILL} state_e;

  state_e             state_q;
  logic               del_q;
  logic               dir_q;
  logic [AW-1:0]      idx_q;
  logic [ENTRY_W-1:0] data_q;
  logic               dn_del_q;
  logic [RAMLEVEL-1:0] dn_idx_q;
  logic [ENTRY_W-1:0] dn_data_q;
  logic [AW-1:0]      fill_addr_q;
  logic               overflow_q;

  logic               a_v, b_v, pick_b, ins_lt;
  logic [ENTRY_W-1:0] chosen, fwd_entry;
  logic [AW-1:0]      chosen_addr;

  // Delete idx always has LSB 0, so OR-ing in the pick bit selects the sibling.
  always_comb begin
    a_v         = ram_q_a[ENTRY_W-1];
    b_v         = ram_q_b[ENTRY_W-1];
    pick_b      = b_v && (!a_v || (ram_q_b[KEY_W-1:0] < ram_q_a[KEY_W-1:0]));
    chosen      = pick_b ? ram_q_b : ram_q_a;
    chosen_addr = idx_q | AW'(pick_b);
    ins_lt      = data_q[KEY_W-1:0] < ram_q_a[KEY_W-1:0];
    fwd_entry   = ins_lt ? ram_q_a : data_q;
  end

  always_comb begin
    ram_we_a   = 1'b0;
    ram_we_b   = 1'b0;
    ram_addr_a = idx_q;
    ram_addr_b = idx_q | AW'(1);
    ram_wd_a   = data_q;
    ram_wd_b   = '0;
    case (state_q)
      S_IDLE: begin
        ram_addr_a = op_idx;
        ram_addr_b = op_del ? (op_idx | AW'(1)) : op_idx;
      end
      S_CMP: begin
        if (!del_q) begin
          ram_we_a = !a_v || ins_lt;
        end else if ((LAST_LEVEL != 0) && (a_v || b_v)) begin
          ram_we_a   = 1'b1;
          ram_addr_a = chosen_addr;
          ram_wd_a   = '0;
        end
      end
      S_WAIT_FILL: begin
        ram_we_a   = fill_valid;
        ram_addr_a = fill_addr_q;
        ram_wd_a   = fill_data;
      end
      default: ;
    endcase
  end

  assign op_ready = (state_q == S_IDLE);
  assign dn_valid = (state_q == S_FWD);
  assign up_valid = (state_q == S_CMP) && del_q;
  assign up_data  = chosen;
  assign dn_del   = dn_del_q;
  assign dn_idx   = dn_idx_q;
  assign dn_data  = dn_data_q;
  assign overflow = overflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      del_q       <= 1'b0;
      dir_q       <= 1'b0;
      idx_q       <= '0;
      data_q      <= '0;
      dn_del_q    <= 1'b0;
      dn_idx_q    <= '0;
      dn_data_q   <= '0;
      fill_addr_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_valid) begin
            del_q   <= op_del;
            dir_q   <= op_dir;
            idx_q   <= op_idx;
            data_q  <= op_data;
            state_q <= S_CMP;
          end
        end
        S_CMP: begin
          if (!del_q) begin
            if (!a_v) begin
              state_q <= S_IDLE;
            end else if (LAST_LEVEL != 0) begin
              overflow_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              dn_data_q <= fwd_entry;
              dn_idx_q  <= {idx_q, dir_q};
              dn_del_q  <= 1'b0;
              state_q   <= S_FWD;
            end
          end else if (!(a_v || b_v) || (LAST_LEVEL != 0)) begin
            state_q <= S_IDLE;
          end else begin
            dn_data_q   <= '0;
            dn_idx_q    <= {chosen_addr, 1'b0};
            dn_del_q    <= 1'b1;
            fill_addr_q <= chosen_addr;
            state_q     <= S_FWD;
          end
        end
        S_FWD: begin
          if (dn_ready) state_q <= dn_del_q ? S_WAIT_FILL : S_IDLE;
        end
        S_WAIT_FILL: begin
          if (fill_valid) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef PHEAP_LEVEL_STATS_EN
  logic [15:0] ins_cnt_q, del_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ins_cnt_q <= '0;
      del_cnt_q <= '0;
    end else if (op_valid && (state_q == S_IDLE)) begin
      if (!op_del && (ins_cnt_q != 16'hFFFF)) ins_cnt_q <= ins_cnt_q + 16'd1;
      if (op_del && (del_cnt_q != 16'hFFFF)) del_cnt_q <= del_cnt_q + 16'd1;
    end
  end

  assign ins_cnt = ins_cnt_q;
  assign del_cnt = del_cnt_q;
`endif

endmodule

// File: tb/tb_pheap_level_ctrl.sv
// Directed bench: two RAMLEVEL=3 controllers (inner and last level), each with its own RAM model.
module tb_pheap_level_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // inner level (LAST_LEVEL=0)
  logic        op_valid0 = 0, op_del0 = 0, op_dir0 = 0, dn_ready0 = 0, fill_valid0 = 0;
  logic [1:0]  op_idx0 = 0;
  logic [15:0] op_data0 = 0, fill_data0 = 0;
  logic        op_ready0, up_valid0, dn_valid0, dn_del0, we_a0, we_b0, ovf0;
  logic [15:0] up_data0, dn_data0, wd_a0, wd_b0, q_a0, q_b0;
  logic [2:0]  dn_idx0;
  logic [1:0]  addr_a0, addr_b0;
  logic [15:0] mem0 [4];

  // last level (LAST_LEVEL=1)
  logic        op_valid1 = 0, op_del1 = 0, op_dir1 = 0, dn_ready1 = 0, fill_valid1 = 0;
  logic [1:0]  op_idx1 = 0;
  logic [15:0] op_data1 = 0, fill_data1 = 0;
  logic        op_ready1, up_valid1, dn_valid1, dn_del1, we_a1, we_b1, ovf1;
  logic [15:0] up_data1, dn_data1, wd_a1, wd_b1, q_a1, q_b1;
  logic [2:0]  dn_idx1;
  logic [1:0]  addr_a1, addr_b1;
  logic [15:0] mem1 [4];

  logic        pre_we = 0, pre_sel = 0;
  logic [1:0]  pre_addr = 0;
  logic [15:0] pre_data = 0;

  pheap_level_ctrl #(.RAMLEVEL(3), .ENTRY_W(16), .KEY_W(8), .LAST_LEVEL(0)) dut0 (
    .clk(clk), .rst(rst), .op_valid(op_valid0), .op_ready(op_ready0), .op_del(op_del0),
    .op_idx(op_idx0), .op_dir(op_dir0), .op_data(op_data0), .up_valid(up_valid0),
    .up_data(up_data0), .dn_valid(dn_valid0), .dn_ready(dn_ready0), .dn_del(dn_del0),
    .dn_idx(dn_idx0), .dn_data(dn_data0), .fill_valid(fill_valid0), .fill_data(fill_data0),
    .ram_we_a(we_a0), .ram_we_b(we_b0), .ram_addr_a(addr_a0), .ram_addr_b(addr_b0),
    .ram_wd_a(wd_a0), .ram_wd_b(wd_b0), .ram_q_a(q_a0), .ram_q_b(q_b0), .overflow(ovf0)
  );

  pheap_level_ctrl #(.RAMLEVEL(3), .ENTRY_W(16), .KEY_W(8), .LAST_LEVEL(1)) dut1 (
    .clk(clk), .rst(rst), .op_valid(op_valid1), .op_ready(op_ready1), .op_del(op_del1),
    .op_idx(op_idx1), .op_dir(op_dir1), .op_data(op_data1), .up_valid(up_valid1),
    .up_data(up_data1), .dn_valid(dn_valid1), .dn_ready(dn_ready1), .dn_del(dn_del1),
    .dn_idx(dn_idx1), .dn_data(dn_data1), .fill_valid(fill_valid1), .fill_data(fill_data1),
    .ram_we_a(we_a1), .ram_we_b(we_b1), .ram_addr_a(addr_a1), .ram_addr_b(addr_b1),
    .ram_wd_a(wd_a1), .ram_wd_b(wd_b1), .ram_q_a(q_a1), .ram_q_b(q_b1), .overflow(ovf1)
  );

  // Dual-port RAM models: 1-cycle read, a port's read output holds while it writes.
  always @(posedge clk) begin
    if (pre_we && !pre_sel) mem0[pre_addr] <= pre_data;
    if (we_a0) mem0[addr_a0] <= wd_a0; else q_a0 <= mem0[addr_a0];
    if (we_b0) mem0[addr_b0] <= wd_b0; else q_b0 <= mem0[addr_b0];
  end
  always @(posedge clk) begin
    if (pre_we && pre_sel) mem1[pre_addr] <= pre_data;
    if (we_a1) mem1[addr_a1] <= wd_a1; else q_a1 <= mem1[addr_a1];
    if (we_b1) mem1[addr_b1] <= wd_b1; else q_b1 <= mem1[addr_b1];
  end

  function automatic logic [15:0] ent(input logic [7:0] key);
    return {8'h80, key};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic sel, input logic [1:0] a, input logic [15:0] d);
    pre_we = 1; pre_sel = sel; pre_addr = a; pre_data = d;
    tick();
    pre_we = 0;
  endtask

  initial begin
    // reset
    #2;
    chk("rst_op_ready", op_ready0, 1);
    chk("rst_dn_valid", dn_valid0, 0);
    chk("rst_up_valid", up_valid0, 0);
    chk("rst_overflow", ovf0, 0);
    chk("rst_we_a", we_a0, 0);
    chk("rst_overflow1", ovf1, 0);
    for (int i = 0; i < 4; i++) begin
      preload(0, 2'(i), 16'h0);
      preload(1, 2'(i), 16'h0);
    end
    tick();
    rst = 0;
    tick();

    // insert into an empty slot
    op_valid0 = 1; op_del0 = 0; op_idx0 = 2; op_dir0 = 0; op_data0 = ent(8'h10);
    #1 chk("ins1_rd_addr", addr_a0, 2);
    tick(); op_valid0 = 0;
    #1 chk("ins1_we_a", we_a0, 1);
    chk("ins1_addr_a", addr_a0, 2);
    chk("ins1_wd_a", wd_a0, 16'h8010);
    chk("ins1_no_dn", dn_valid0, 0);
    chk("ins1_we_b", we_b0, 0);
    tick();
    chk("ins1_ready", op_ready0, 1);
    chk("ins1_mem", mem0[2], 16'h8010);
    $display("insert idx=2 key=10 done");

    // insert smaller key: swap and forward stored entry, hold under backpressure
    preload(0, 2'd1, ent(8'h20));
    op_valid0 = 1; op_idx0 = 1; op_dir0 = 1; op_data0 = ent(8'h05);
    tick(); op_valid0 = 0;
    #1 chk("ins2_we_a", we_a0, 1);
    chk("ins2_wd_a", wd_a0, 16'h8005);
    chk("ins2_addr_a", addr_a0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ins2_dn_valid", dn_valid0, 1);
      chk("ins2_dn_data", dn_data0, 16'h8020);
      chk("ins2_dn_idx", dn_idx0, 3'b011);
      chk("ins2_dn_del", dn_del0, 0);
      chk("ins2_busy", op_ready0, 0);
    end
    dn_ready0 = 1;
    tick(); dn_ready0 = 0;
    chk("ins2_ready", op_ready0, 1);
    chk("ins2_mem", mem0[1], 16'h8005);
    $display("insert idx=1 key=05 forwarded key=20");

    // delete picks smaller child B, then refill
    preload(0, 2'd2, ent(8'h30));
    preload(0, 2'd3, ent(8'h18));
    op_valid0 = 1; op_del0 = 1; op_idx0 = 2;
    #1 chk("del1_addr_b", addr_b0, 3);
    tick(); op_valid0 = 0; op_del0 = 0;
    #1 chk("del1_up_valid", up_valid0, 1);
    chk("del1_up_data", up_data0, 16'h8018);
    chk("del1_no_we", we_a0, 0);
    tick();
    chk("del1_up_pulse", up_valid0, 0);
    chk("del1_dn_valid", dn_valid0, 1);
    chk("del1_dn_idx", dn_idx0, 3'b110);
    chk("del1_dn_del", dn_del0, 1);
    dn_ready0 = 1;
    tick(); dn_ready0 = 0;
    chk("del1_wait_busy", op_ready0, 0);
    chk("del1_wait_dn", dn_valid0, 0);
    fill_valid0 = 1; fill_data0 = ent(8'h40);
    #1 chk("del1_fill_we", we_a0, 1);
    chk("del1_fill_addr", addr_a0, 3);
    chk("del1_fill_wd", wd_a0, 16'h8040);
    tick(); fill_valid0 = 0;
    chk("del1_ready", op_ready0, 1);
    chk("del1_mem", mem0[3], 16'h8040);
    $display("delete idx=2 returned key=18 refilled key=40");

    // tie picks A
    preload(0, 2'd2, ent(8'h22));
    preload(0, 2'd3, ent(8'h22));
    op_valid0 = 1; op_del0 = 1; op_idx0 = 2;
    tick(); op_valid0 = 0; op_del0 = 0;
    #1 chk("tie_up_data", up_data0, 16'h8022);
    tick();
    chk("tie_dn_idx", dn_idx0, 3'b100);
    dn_ready0 = 1;
    tick(); dn_ready0 = 0;
    fill_valid0 = 1; fill_data0 = ent(8'h50);
    #1 chk("tie_fill_addr", addr_a0, 2);
    tick(); fill_valid0 = 0;
    chk("tie_mem", mem0[2], 16'h8050);
    $display("delete tie picked addr2");

    // both children invalid
    preload(0, 2'd0, 16'h0);
    preload(0, 2'd1, 16'h0);
    op_valid0 = 1; op_del0 = 1; op_idx0 = 0;
    tick(); op_valid0 = 0; op_del0 = 0;
    #1 chk("empty_up_valid", up_valid0, 1);
    chk("empty_up_vbit", up_data0[15], 0);
    chk("empty_no_we", we_a0, 0);
    tick();
    chk("empty_ready", op_ready0, 1);
    chk("empty_no_dn", dn_valid0, 0);
    $display("delete of empty pair returned invalid");

    // reset during WAIT_FILL (mem2=50, mem3=22 -> picks addr3)
    op_valid0 = 1; op_del0 = 1; op_idx0 = 2;
    tick(); op_valid0 = 0; op_del0 = 0;
    tick();
    dn_ready0 = 1;
    tick(); dn_ready0 = 0;
    chk("rw_in_wait", op_ready0, 0);
    rst = 1;
    #1 chk("rw_dn_valid", dn_valid0, 0);
    chk("rw_op_ready", op_ready0, 1);
    tick(); rst = 0;
    fill_valid0 = 1; fill_data0 = ent(8'h77);
    #1 chk("rw_no_we", we_a0, 0);
    tick(); fill_valid0 = 0;
    chk("rw_mem3", mem0[3], 16'h8022);
    chk("rw_ready", op_ready0, 1);
    $display("reset during wait_fill aborted token");

    // last level: insert overflow
    preload(1, 2'd0, ent(8'h07));
    op_valid1 = 1; op_del1 = 0; op_idx1 = 0; op_data1 = ent(8'h09);
    tick(); op_valid1 = 0;
    #1 chk("ovf_no_we", we_a1, 0);
    tick();
    chk("ovf_set", ovf1, 1);
    chk("ovf_ready", op_ready1, 1);
    chk("ovf_no_dn", dn_valid1, 0);
    chk("ovf_mem0", mem1[0], 16'h8007);
    $display("last-level insert key=09 overflowed");

    // last level: delete lone valid entry clears it
    op_valid1 = 1; op_del1 = 1; op_idx1 = 0;
    tick(); op_valid1 = 0; op_del1 = 0;
    #1 chk("ll_up_data", up_data1, 16'h8007);
    chk("ll_we_a", we_a1, 1);
    chk("ll_addr_a", addr_a1, 0);
    chk("ll_wd_a", wd_a1, 16'h0);
    tick();
    chk("ll_ready", op_ready1, 1);
    chk("ll_no_dn", dn_valid1, 0);
    chk("ll_mem0", mem1[0], 16'h0);
    tick(); tick();
    chk("ovf_sticky", ovf1, 1);
    $display("last-level delete cleared addr0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pheap_level_ctrl.md
Name: pheap_level_ctrl

Overview:
- Sequences one level of the pipelined heap: owns the two ports of that level's dual-port level RAM (1-cycle read latency, read output holds its value during writes).
- Accepts insert/delete tokens from the level above, does read-compare-write, passes tokens to the level below, and returns the minimum child upward on deletes.
- Min-heap; one instance per level.

Parameters:
- RAMLEVEL, 2: heap level served (≥2); RAM depth 2**(RAMLEVEL-1), address width AW = RAMLEVEL-1.
- ENTRY_W, 16: entry width. Bit ENTRY_W-1 = valid, bits KEY_W-1:0 = key, bits between = payload.
- KEY_W, 8: key width, unsigned compare.
- LAST_LEVEL, 0: 1 = bottom level, never forwards downward.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- op_valid  in  1  upstream token valid
- op_ready  out  1  controller idle and able to accept
- op_del  in  1  0 = insert, 1 = delete
- op_idx  in  AW  insert: target address; delete: left child address (LSB must be 0)
- op_dir  in  1  insert: path bit for the next level
- op_data  in  ENTRY_W  insert entry
- up_valid  out  1  one-cycle pulse carrying the deleted-min replacement upward
- up_data  out  ENTRY_W  replacement entry (valid bit 0 = empty)
- dn_valid  out  1  downstream token valid
- dn_ready  in  1  downstream accepts
- dn_del, dn_idx[RAMLEVEL], dn_data[ENTRY_W]  out  -  downstream token
- fill_valid  in  1  replacement from below (= the lower level's up_valid)
- fill_data  in  ENTRY_W  replacement entry
- ram_we_a, ram_we_b  out  1  RAM write enables
- ram_addr_a, ram_addr_b  out  AW  RAM addresses
- ram_wd_a, ram_wd_b  out  ENTRY_W  RAM write data
- ram_q_a, ram_q_b  in  ENTRY_W  RAM read data
- overflow  out  1  sticky: an insert fell off the last level

Behaviour:
- Reset (async, rst=1): state IDLE, op_ready=1, dn_valid=0, up_valid=0, overflow=0, all write enables 0. RAM contents are untouched.
- Reset mid-operation aborts the token; nothing half-written remains pending.
- States: IDLE, CMP, FWD, WAIT_FILL.
- IDLE:
  - op_ready=1.
  - On op_valid: latch the token, drive reads combinationally in the same cycle. ram_addr_a=op_idx; ram_addr_b=op_idx|1 (delete only).
  - Go to CMP.
- CMP, insert (stored = ram_q_a):
  - If stored is invalid: write op_data at op_idx, go to IDLE.
  - Else if op key < stored key: write op_data; forward stored.
  - Else: forward op_data. Ties forward the new entry.
  - Forwarding with LAST_LEVEL=0: dn_idx={op_idx,op_dir}, dn_del=0, go to FWD.
  - Forwarding with LAST_LEVEL=1: set overflow, drop the entry, go to IDLE.
- CMP, delete:
  - Chosen = the smaller valid of ram_q_a/ram_q_b. Tie picks A. A lone valid entry is chosen. If both are invalid, the result is invalid.
  - Pulse up_valid with up_data=chosen.
  - Both invalid: go to IDLE.
  - LAST_LEVEL=1: write an invalid entry (all zeros) to the chosen address, go to IDLE.
  - Otherwise: dn_del=1, dn_idx={chosen_addr,1'b0}, go to FWD.
- FWD:
  - dn_valid=1; dn_* held stable until dn_ready.
  - On handshake: insert goes to IDLE; delete goes to WAIT_FILL.
- WAIT_FILL: on fill_valid, write fill_data to the chosen address via port A, go to IDLE.
- fill_valid in any other state is ignored.
- Port B is never written. Read-only cycles keep both write enables low.
- Throughput: insert with no forward takes 2 cycles; delete takes at least 4 cycles plus downstream latency.

Optional Feature:
- Macro PHEAP_LEVEL_STATS_EN.
- Defined: adds output ports ins_cnt[15:0] and del_cnt[15:0]. Each increments on an accepted insert/delete, saturates at 0xFFFF, and resets to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- RAMLEVEL=3, RAM all invalid; insert idx=2, key 0x10 → cycle+1: ram_we_a=1, addr 2, data key 0x10; no dn_valid; op_ready=1 at cycle+2.
- addr1 holds key 0x20; insert idx=1, dir=1, key 0x05 → write 0x05 at addr1; dn_valid with dn_data key 0x20, dn_idx=3'b011, dn_del=0; hold 3 cycles with dn_ready=0 and check dn_* stable.
- addr2=0x30, addr3=0x18; delete idx=2 → up_valid pulse with key 0x18; dn_idx=3'b110, dn_del=1; fill_valid with key 0x40 → ram_we_a addr 3 data 0x40; then IDLE.
- addr2=addr3 both key 0x22 → delete picks addr2 (dn_idx=3'b100). Both invalid → up_data valid bit 0, no dn_valid.
- LAST_LEVEL=1, addr0 holds 0x07; insert idx=0, key 0x09 → no write, overflow=1 and stays set. Delete of a lone valid entry → zero written to its address.
- Assert rst during WAIT_FILL → dn_valid=0 and op_ready=1 immediately; a later fill_valid causes no RAM write.
